// File: rtl/alu_pipelined.sv
// Registered integer ALU with valid/ready on both sides and a selectable
// barrel or bit-serial shifter; illegal opcodes yield a zero result plus a flag.
module alu_pipelined #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter bit          SERIAL_SHIFT = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic [3:0]            opcode_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  illegal_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    localparam int unsigned SW = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLT  = 4'd2,  OP_SLTU = 4'd3,
        OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MIN  = 4'd10, OP_MAX  = 4'd11,
        OP_MINU = 4'd12, OP_MAXU = 4'd13
    } opcode_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_e;

    state_e                r_state,   w_state_nxt;
    logic [SW-1:0]         r_count,   w_count_nxt;
    logic [DATA_WIDTH-1:0] r_work,    w_work_nxt;
    shift_e                r_shtype,  w_shtype_nxt;
    logic [DATA_WIDTH-1:0] r_result,  w_result_nxt;
    logic                  r_illegal, w_illegal_nxt;
    logic                  r_valid,   w_valid_nxt;

    logic [SW-1:0]         w_shamt;
    logic                  w_lt_s;
    logic                  w_lt_u;
    logic                  w_is_shift;
    logic                  w_serial_start;
    logic                  w_slot_free;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_illegal;
    logic [DATA_WIDTH-1:0] w_work_step;
    shift_e                w_shtype_in;

    assign w_shamt    = operand_b_i[SW-1:0];
    assign w_lt_s     = $signed(operand_a_i) < $signed(operand_b_i);
    assign w_lt_u     = operand_a_i < operand_b_i;
    assign w_is_shift = (opcode_i == OP_SLL) || (opcode_i == OP_SRL) || (opcode_i == OP_SRA);

    always_comb begin
        w_alu_result  = '0;
        w_alu_illegal = 1'b0;
        case (opcode_i)
            OP_ADD:  w_alu_result = operand_a_i + operand_b_i;
            OP_SUB:  w_alu_result = operand_a_i - operand_b_i;
            OP_SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
            OP_SLTU: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
            OP_AND:  w_alu_result = operand_a_i & operand_b_i;
            OP_OR:   w_alu_result = operand_a_i | operand_b_i;
            OP_XOR:  w_alu_result = operand_a_i ^ operand_b_i;
            OP_SLL:  w_alu_result = operand_a_i << w_shamt;
            OP_SRL:  w_alu_result = operand_a_i >> w_shamt;
            OP_SRA:  w_alu_result = $signed(operand_a_i) >>> w_shamt;
            OP_MIN:  w_alu_result = w_lt_s ? operand_a_i : operand_b_i;
            OP_MAX:  w_alu_result = w_lt_s ? operand_b_i : operand_a_i;
            OP_MINU: w_alu_result = w_lt_u ? operand_a_i : operand_b_i;
            OP_MAXU: w_alu_result = w_lt_u ? operand_b_i : operand_a_i;
            default: w_alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        if (opcode_i == OP_SLL) begin
            w_shtype_in = SH_SLL;
        end else if (opcode_i == OP_SRL) begin
            w_shtype_in = SH_SRL;
        end else begin
            w_shtype_in = SH_SRA;
        end
    end

    // One bit position per step; SRA re-feeds the current MSB of the work register.
    always_comb begin
        case (r_shtype)
            SH_SLL:  w_work_step = {r_work[DATA_WIDTH-2:0], 1'b0};
            SH_SRL:  w_work_step = {1'b0, r_work[DATA_WIDTH-1:1]};
            default: w_work_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
        endcase
    end

    assign w_slot_free    = !r_valid || ready_i;
    assign ready_o        = (r_state == ST_IDLE) && w_slot_free;
    assign w_accept       = valid_i && ready_o;
    assign w_serial_start = SERIAL_SHIFT && w_is_shift && (w_shamt != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_work_nxt    = r_work;
        w_shtype_nxt  = r_shtype;
        w_result_nxt  = r_result;
        w_illegal_nxt = r_illegal;
        w_valid_nxt   = r_valid;

        // A consume clears valid; any load below in the same cycle overrides it.
        if (r_valid && ready_i) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_serial_start) begin
                        w_state_nxt  = ST_SHIFT;
                        w_work_nxt   = operand_a_i;
                        w_count_nxt  = w_shamt;
                        w_shtype_nxt = w_shtype_in;
                    end else begin
                        w_result_nxt  = w_alu_result;
                        w_illegal_nxt = w_alu_illegal;
                        w_valid_nxt   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (r_count != '0) begin
                    w_work_nxt  = w_work_step;
                    w_count_nxt = r_count - SW'(1);
                end else if (w_slot_free) begin
                    w_result_nxt  = r_work;
                    w_illegal_nxt = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_work    <= '0;
            r_shtype  <= SH_SLL;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_work    <= w_work_nxt;
            r_shtype  <= w_shtype_nxt;
            r_result  <= w_result_nxt;
            r_illegal <= w_illegal_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign result_o  = r_result;
    assign illegal_o = r_illegal;
    assign valid_o   = r_valid;

endmodule

// File: tb/tb_alu_pipelined.sv
// Scoreboard bench for alu_pipelined: index 0 is a barrel-shift instance,
// index 1 a serial-shift instance; each has its own expected-result queue.
module tb_alu_pipelined;
    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        logic [15:0] tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a    [2];
    logic [31:0] b    [2];
    logic [3:0]  op   [2];
    logic        vin  [2];
    logic        rdy  [2];
    logic [31:0] res  [2];
    logic        ill  [2];
    logic        vout [2];
    logic        rin  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   ncmp;
    int   nerr;
    int   tag;

    alu_pipelined #(.DATA_WIDTH(32), .SERIAL_SHIFT(1'b0)) u_dut_bar (
        .clk_i(clk), .rst_n_i(rst_n),
        .operand_a_i(a[0]), .operand_b_i(b[0]), .opcode_i(op[0]),
        .valid_i(vin[0]), .ready_o(rdy[0]),
        .result_o(res[0]), .illegal_o(ill[0]), .valid_o(vout[0]), .ready_i(rin[0])
    );

    alu_pipelined #(.DATA_WIDTH(32), .SERIAL_SHIFT(1'b1)) u_dut_ser (
        .clk_i(clk), .rst_n_i(rst_n),
        .operand_a_i(a[1]), .operand_b_i(b[1]), .opcode_i(op[1]),
        .valid_i(vin[1]), .ready_o(rdy[1]),
        .result_o(res[1]), .illegal_o(ill[1]), .valid_o(vout[1]), .ready_i(rin[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input int d, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e, input logic il);
        logic acc;
        exp_t ent;
        acc = 1'b0;
        a[d] = x; b[d] = y; op[d] = o; vin[d] = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = rdy[d];
            @(posedge clk);
            #1;
        end
        vin[d] = 1'b0;
        if (!acc) begin
            ncmp++;
            nerr++;
            $display("FAIL d%0d_accept_timeout: got no accept expected accept (op %0d)", d, o);
        end else begin
            ent.res = e; ent.ill = il; ent.tag = tag[15:0];
            tag++;
            if (d == 0) q0.push_back(ent);
            else        q1.push_back(ent);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        logic empty;
        forever begin
            @(negedge clk);
            if (rst_n && vout[d] && rin[d]) begin
                empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL d%0d_unexpected_output: got %h expected none", d, res[d]);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("d%0d_result_t%0d", d, e.tag), res[d], e.res);
                    chk($sformatf("d%0d_illegal_t%0d", d, e.tag), {31'b0, ill[d]}, {31'b0, e.ill});
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        ncmp = 0; nerr = 0; tag = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            a[d] = '0; b[d] = '0; op[d] = '0; vin[d] = 1'b0; rin[d] = 1'b1;
        end
        fork
            mon(0);
            mon(1);
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", res[1], 32'h0);
        chk("rst_illegal", ill[1], 1'b0);
        chk("rst_valid", vout[1], 1'b0);
        chk("rst_ready", rdy[1], 1'b1);
        chk("rst_ready_bar", rdy[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", rdy[1], 1'b1);

        // Barrel instance, streamed back to back
        issue(0, 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        issue(0, 4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1);
        issue(0, 4'd7,  32'h00000001, 32'd31,       32'h80000000, 1'b0);
        issue(0, 4'd8,  32'h80000000, 32'd31,       32'h00000001, 1'b0);
        issue(0, 4'd9,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0);
        issue(0, 4'd9,  32'h80000000, 32'd0,        32'h80000000, 1'b0);
        issue(0, 4'd8,  32'hF0000000, 32'hFFFFFF24, 32'h0F000000, 1'b0);
        issue(0, 4'd7,  32'h12345678, 32'd8,        32'h34567800, 1'b0);
        issue(0, 4'd9,  32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0);
        wait_drain();

        // Serial instance: ALU ops and illegal opcodes
        issue(1, 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        chk("add_latency1", vout[1], 1'b1);
        issue(1, 4'd15, 32'h00000007, 32'h00000003, 32'h00000000, 1'b1);
        issue(1, 4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        issue(1, 4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        issue(1, 4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        issue(1, 4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        issue(1, 4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        issue(1, 4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        issue(1, 4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        issue(1, 4'd10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        issue(1, 4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        issue(1, 4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        issue(1, 4'd13, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        wait_drain();

        // Back-pressure: first result held for three cycles
        issue(1, 4'd0, 32'd1, 32'd1, 32'd2, 1'b0);
        rin[1] = 1'b0;
        fork
            begin
                issue(1, 4'd0, 32'd2, 32'd2, 32'd4, 1'b0);
                issue(1, 4'd0, 32'd3, 32'd3, 32'd6, 1'b0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_hold_result", res[1], 32'd2);
                    chk("bp_hold_valid", vout[1], 1'b1);
                    chk("bp_ready_low", rdy[1], 1'b0);
                    @(posedge clk);
                    #1;
                end
                rin[1] = 1'b1;
            end
        join
        wait_drain();

        // Serial SRA by 31: ready low for 32 cycles, result 32 cycles after accept
        issue(1, 4'd9, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy[1]) break;
            cnt++;
        end
        chk("sra31_ready_low_cycles", cnt, 32);
        chk("sra31_valid_at_return", vout[1], 1'b1);
        @(posedge clk);
        #1;
        issue(1, 4'd8, 32'd5, 32'd0, 32'd5, 1'b0);
        chk("srl0_latency1", vout[1], 1'b1);
        chk("srl0_ready", rdy[1], 1'b1);
        issue(1, 4'd7, 32'h00000001, 32'd31,       32'h80000000, 1'b0);
        issue(1, 4'd8, 32'hF0000000, 32'hFFFFFF24, 32'h0F000000, 1'b0);
        issue(1, 4'd9, 32'h40000000, 32'd2,        32'h10000000, 1'b0);
        issue(1, 4'd9, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0);
        wait_drain();

        // Serial shift issued behind a held result
        issue(1, 4'd0, 32'd10, 32'd10, 32'd20, 1'b0);
        rin[1] = 1'b0;
        fork
            issue(1, 4'd7, 32'h1, 32'd4, 32'h10, 1'b0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("blk_hold_result", res[1], 32'd20);
                    chk("blk_ready_low", rdy[1], 1'b0);
                    @(posedge clk);
                    #1;
                end
                rin[1] = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of an SLL by 20, after step 7
        issue(1, 4'd7, 32'h1, 32'd20, 32'h00100000, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        chk("pre_rst_busy", rdy[1], 1'b0);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("midrst_result", res[1], 32'h0);
        chk("midrst_result_bar", res[0], 32'h0);
        chk("midrst_illegal", ill[1], 1'b0);
        chk("midrst_valid", vout[1], 1'b0);
        chk("midrst_ready", rdy[1], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_ready", rdy[1], 1'b1);
        chk("after_rst_valid", vout[1], 1'b0);
        issue(1, 4'd0, 32'd3, 32'd4, 32'd7, 1'b0);
        chk("after_rst_add_valid", vout[1], 1'b1);
        chk("after_rst_add_result", res[1], 32'd7);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
